// File: rtl/gmii_udp_stream_rx.sv
// gmii_udp_stream_rx: GMII receive path that accepts IPv4/UDP packets addressed to
// this receiver (IPV4_DST_BASE low byte + id, DST_PORT) and splits the payload by type:
// 0x00 video, 0x01 audio/aux, 0x02 video followed by aux bytes.
// Ports:
//   clk125, sys_rst_n        GMII RX clock, asynchronous active-low reset
//   id                       receiver index added to the IP low byte (no carry)
//   rxd, rx_dv, rx_er        GMII receive data / valid / error
//   vid_full                 video FIFO full
//   vid_din, vid_wr_en       {x[3:0], y[11:0], pixel bytes (first byte in MSBs)}, write strobe
//   aux_din, aux_wr_en       {sop, eop, byte}, write strobe
//   pkt_ok_cnt, pkt_drop_cnt accepted / aborted-after-accept packets, saturating
//   vid_ovf                  sticky flag: a video word was lost to vid_full
module gmii_udp_stream_rx #(
  parameter logic [31:0] IPV4_DST_BASE = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter int unsigned ID_W          = 1,
  parameter int unsigned PIX_BYTES     = 2,
  parameter int unsigned PAYLOAD_BYTES = 1200
) (
  input  logic                     clk125,
  input  logic                     sys_rst_n,
  input  logic [ID_W-1:0]          id,
  input  logic [7:0]               rxd,
  input  logic                     rx_dv,
  input  logic                     rx_er,
  input  logic                     vid_full,
  output logic [16+8*PIX_BYTES-1:0] vid_din,
  output logic                     vid_wr_en,
  output logic [9:0]               aux_din,
  output logic                     aux_wr_en,
  output logic [15:0]              pkt_ok_cnt,
  output logic [15:0]              pkt_drop_cnt,
  output logic                     vid_ovf
);

  localparam int unsigned PIX_W = 8 * PIX_BYTES;
  localparam int unsigned VID_W = 16 + PIX_W;
  localparam int unsigned SR_W  = 8 * (PIX_BYTES - 1);

  localparam logic [10:0] PIX_LAST  = 11'(PAYLOAD_BYTES - 1);
  localparam logic [1:0]  WORD_LAST = 2'(PIX_BYTES - 1);
  // UDP header (8) + type (1) + x/y (2) + pixel payload precede the aux bytes
  localparam logic [15:0] VIDAX_OFF = 16'(11 + PAYLOAD_BYTES);

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_VID  = 3'd3;
  localparam logic [2:0] S_AUD  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;

  logic [2:0]       state, state_n;
  logic [5:0]       b_idx, b_idx_n;
  logic [15:0]      eth_type, eth_type_n;
  logic [7:0]       ip_ver, ip_ver_n;
  logic [7:0]       ip_proto, ip_proto_n;
  logic [31:0]      dst_ip, dst_ip_n;
  logic [15:0]      dst_port, dst_port_n;
  logic [15:0]      udp_len, udp_len_n;
  logic             vidax, vidax_n;
  logic [3:0]       vid_x, vid_x_n;
  logic [11:0]      vid_y, vid_y_n;
  logic [10:0]      pix_cnt, pix_cnt_n;
  logic [1:0]       word_pos, word_pos_n;
  logic [SR_W-1:0]  word_sr, word_sr_n;
  logic [15:0]      aux_rem, aux_rem_n;
  logic             aux_first, aux_first_n;
  logic [VID_W-1:0] vid_din_n;
  logic             vid_wr_en_n;
  logic [9:0]       aux_din_n;
  logic             aux_wr_en_n;
  logic [15:0]      pkt_ok_cnt_n, pkt_drop_cnt_n;
  logic             vid_ovf_n;
  logic             hdr_match_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // All header fields are latched before the type byte, so the match is stable at b42
  assign hdr_match_c = (eth_type == 16'h0800) && (ip_ver == 8'h45) && (ip_proto == 8'h11) &&
                       (dst_ip == {IPV4_DST_BASE[31:8], IPV4_DST_BASE[7:0] + 8'(id)}) &&
                       (dst_port == DST_PORT);

  // Next-state and next-output logic
  always_comb begin
    state_n        = state;
    b_idx_n        = b_idx;
    eth_type_n     = eth_type;
    ip_ver_n       = ip_ver;
    ip_proto_n     = ip_proto;
    dst_ip_n       = dst_ip;
    dst_port_n     = dst_port;
    udp_len_n      = udp_len;
    vidax_n        = vidax;
    vid_x_n        = vid_x;
    vid_y_n        = vid_y;
    pix_cnt_n      = pix_cnt;
    word_pos_n     = word_pos;
    word_sr_n      = word_sr;
    aux_rem_n      = aux_rem;
    aux_first_n    = aux_first;
    vid_din_n      = vid_din;
    vid_wr_en_n    = 1'b0;
    aux_din_n      = aux_din;
    aux_wr_en_n    = 1'b0;
    pkt_ok_cnt_n   = pkt_ok_cnt;
    pkt_drop_cnt_n = pkt_drop_cnt;
    vid_ovf_n      = vid_ovf;

    case (state)
      S_IDLE: if (rx_dv) state_n = S_PRE;

      S_PRE: begin
        if (!rx_dv) state_n = S_IDLE;
        else if (rxd == SFD) begin
          state_n = S_HDR;
          b_idx_n = '0;
        end else if (rxd != PREAMBLE) state_n = S_DROP;
      end

      S_HDR: begin
        if (!rx_dv) state_n = S_IDLE;
        else if (rx_er) state_n = S_DROP;
        else begin
          b_idx_n = b_idx + 6'd1;
          case (b_idx)
            6'd12: eth_type_n[15:8] = rxd;
            6'd13: eth_type_n[7:0]  = rxd;
            6'd14: ip_ver_n         = rxd;
            6'd23: ip_proto_n       = rxd;
            6'd30, 6'd31, 6'd32, 6'd33: dst_ip_n = {dst_ip[23:0], rxd};
            6'd36: dst_port_n[15:8] = rxd;
            6'd37: dst_port_n[7:0]  = rxd;
            6'd38: udp_len_n[15:8]  = rxd;
            6'd39: udp_len_n[7:0]   = rxd;
            6'd42: begin
              pix_cnt_n   = '0;
              word_pos_n  = '0;
              aux_first_n = 1'b1;
              if (!hdr_match_c) state_n = S_DROP;
              else begin
                case (rxd)
                  8'h00: begin
                    state_n = S_VID;
                    vidax_n = 1'b0;
                  end
                  8'h02: begin
                    state_n = S_VID;
                    vidax_n = 1'b1;
                  end
                  8'h01: begin
                    if (udp_len > 16'd9) begin
                      state_n   = S_AUD;
                      aux_rem_n = udp_len - 16'd9;
                    end else state_n = S_DONE;
                  end
                  default: state_n = S_DROP;
                endcase
              end
            end
            default: ;
          endcase
        end
      end

      S_VID: begin
        if (!rx_dv || rx_er) begin
          pkt_drop_cnt_n = sat_inc(pkt_drop_cnt);
          state_n        = rx_dv ? S_DROP : S_IDLE;
        end else if (b_idx == 6'd43) begin
          vid_y_n[7:0] = rxd;
          b_idx_n      = 6'd44;
        end else if (b_idx == 6'd44) begin
          vid_x_n       = rxd[7:4];
          vid_y_n[11:8] = rxd[3:0];
          b_idx_n       = 6'd45;
        end else begin
          // Earlier bytes of the word shift in; the final byte is taken straight from rxd
          word_sr_n = SR_W'({word_sr, rxd});
          if (word_pos == WORD_LAST) begin
            word_pos_n = '0;
            if (vid_full) vid_ovf_n = 1'b1;
            else begin
              vid_wr_en_n = 1'b1;
              vid_din_n   = {vid_x, vid_y, word_sr, rxd};
            end
          end else word_pos_n = word_pos + 2'd1;
          if (pix_cnt == PIX_LAST) begin
            if (vidax && (udp_len > VIDAX_OFF)) begin
              state_n   = S_AUD;
              aux_rem_n = udp_len - VIDAX_OFF;
            end else state_n = S_DONE;
          end else pix_cnt_n = pix_cnt + 11'd1;
        end
      end

      S_AUD: begin
        if (!rx_dv || rx_er) begin
          pkt_drop_cnt_n = sat_inc(pkt_drop_cnt);
          state_n        = rx_dv ? S_DROP : S_IDLE;
        end else begin
          aux_wr_en_n = 1'b1;
          aux_din_n   = {aux_first, aux_rem == 16'd1, rxd};
          aux_first_n = 1'b0;
          aux_rem_n   = aux_rem - 16'd1;
          if (aux_rem == 16'd1) state_n = S_DONE;
        end
      end

      S_DONE: begin
        if (!rx_dv) begin
          pkt_ok_cnt_n = sat_inc(pkt_ok_cnt);
          state_n      = S_IDLE;
        end
      end

      S_DROP: if (!rx_dv) state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      b_idx        <= '0;
      eth_type     <= '0;
      ip_ver       <= '0;
      ip_proto     <= '0;
      dst_ip       <= '0;
      dst_port     <= '0;
      udp_len      <= '0;
      vidax        <= 1'b0;
      vid_x        <= '0;
      vid_y        <= '0;
      pix_cnt      <= '0;
      word_pos     <= '0;
      word_sr      <= '0;
      aux_rem      <= '0;
      aux_first    <= 1'b0;
      vid_din      <= '0;
      vid_wr_en    <= 1'b0;
      aux_din      <= '0;
      aux_wr_en    <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      vid_ovf      <= 1'b0;
    end else begin
      state        <= state_n;
      b_idx        <= b_idx_n;
      eth_type     <= eth_type_n;
      ip_ver       <= ip_ver_n;
      ip_proto     <= ip_proto_n;
      dst_ip       <= dst_ip_n;
      dst_port     <= dst_port_n;
      udp_len      <= udp_len_n;
      vidax        <= vidax_n;
      vid_x        <= vid_x_n;
      vid_y        <= vid_y_n;
      pix_cnt      <= pix_cnt_n;
      word_pos     <= word_pos_n;
      word_sr      <= word_sr_n;
      aux_rem      <= aux_rem_n;
      aux_first    <= aux_first_n;
      vid_din      <= vid_din_n;
      vid_wr_en    <= vid_wr_en_n;
      aux_din      <= aux_din_n;
      aux_wr_en    <= aux_wr_en_n;
      pkt_ok_cnt   <= pkt_ok_cnt_n;
      pkt_drop_cnt <= pkt_drop_cnt_n;
      vid_ovf      <= vid_ovf_n;
    end
  end

endmodule
